// File: rtl/apb_reg_slave_pkg.sv
// Shared types and constants for the APB register slave: bus widths, phase
// and decode enums, STATUS field layout and small helpers.
package apb_reg_slave_pkg;

    localparam int APB_ADDR_WIDTH = 8;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_phase_e;

    typedef enum logic [1:0] {DEC_RW, DEC_STATUS, DEC_UNMAPPED} dec_e;

    localparam int         STATUS_CNT_W     = 8;
    localparam int         STATUS_ERR_LSB   = 0;
    localparam int         STATUS_UNMAP_LSB = 8;
    localparam logic [7:0] CNT_MAX          = 8'hFF;

    // Word-aligned addresses only; the slot right after the RW bank is STATUS.
    function automatic dec_e decode_addr(input logic [APB_ADDR_WIDTH-1:0] addr,
                                         input int num_regs);
        dec_e result;
        int   idx;
        idx = int'(addr[APB_ADDR_WIDTH-1:2]);
        if (addr[1:0] != 2'b00)
            result = DEC_UNMAPPED;
        else if (idx < num_regs)
            result = DEC_RW;
        else if (idx == num_regs)
            result = DEC_STATUS;
        else
            result = DEC_UNMAPPED;
        return result;
    endfunction

    function automatic logic [STATUS_CNT_W-1:0] sat_inc(input logic [STATUS_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_prot_fsm.sv
// APB phase tracker: captures the setup request and flags setup, completion
// and protocol violations for the edge at which the inputs are sampled.
//
// state  | meaning
// IDLE   | last edge saw no valid phase (or a violation)
// SETUP  | last edge sampled a setup phase; request captured
// ACCESS | last edge completed a transfer
module apb_prot_fsm
    import apb_reg_slave_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sel,
    input  logic                      enable,
    input  logic                      write,
    input  logic [APB_ADDR_WIDTH-1:0] addr,
    input  logic [APB_DATA_WIDTH-1:0] wdata,
    output logic                      setup_ev,
    output logic                      complete_ev,
    output logic                      viol_ev,
    output logic [APB_ADDR_WIDTH-1:0] cap_addr,
    output logic                      cap_write,
    output logic [APB_DATA_WIDTH-1:0] cap_wdata
);

    apb_phase_e state;
    logic       req_stable;

    assign req_stable = (addr == cap_addr) && (write == cap_write) && (wdata == cap_wdata);

    // Events describe what the upcoming edge does, so the datapath acts on that same edge.
    always_comb begin
        setup_ev    = 1'b0;
        complete_ev = 1'b0;
        viol_ev     = 1'b0;
        if (state == SETUP) begin
            if (sel && enable && req_stable)
                complete_ev = 1'b1;
            else
                viol_ev = 1'b1;
        end else if (sel) begin
            if (enable)
                viol_ev = 1'b1;
            else
                setup_ev = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else if (setup_ev) begin
            state     <= SETUP;
            cap_addr  <= addr;
            cap_write <= write;
            cap_wdata <= wdata;
        end else if (complete_ev) begin
            state <= ACCESS;
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: rtl/apb_reg_slave.sv
// Zero-wait-state APB completer: RW register bank, read-only STATUS counters
// and protocol-violation reporting on top of the phase tracker.
module apb_reg_slave
    import apb_reg_slave_pkg::*;
#(
    parameter int                        NUM_REGS = 8,
    parameter logic [APB_DATA_WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                               PClk,
    input  logic                               Rst,
    input  logic [APB_ADDR_WIDTH-1:0]          PAddr,
    input  logic                               PSel,
    input  logic                               PEnable,
    input  logic                               PWrite,
    input  logic [APB_DATA_WIDTH-1:0]          PWData,
    output logic [APB_DATA_WIDTH-1:0]          PRData,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]                wr_pulse,
    output logic                               proto_err
);

    localparam int W     = APB_DATA_WIDTH;
    localparam int IDX_W = APB_ADDR_WIDTH - 2;

    logic                      setup_ev, complete_ev, viol_ev;
    logic [APB_ADDR_WIDTH-1:0] cap_addr;
    logic                      cap_write;
    logic [W-1:0]              cap_wdata;

    logic [W-1:0]              regs [NUM_REGS];
    logic [STATUS_CNT_W-1:0]   err_cnt, unmap_cnt;
    logic [W-1:0]              status_word, rd_data;
    dec_e                      rd_dec, cmp_dec;
    logic [IDX_W-1:0]          rd_idx, cap_idx;

    apb_prot_fsm u_fsm (
        .clk         (PClk),
        .rst         (Rst),
        .sel         (PSel),
        .enable      (PEnable),
        .write       (PWrite),
        .addr        (PAddr),
        .wdata       (PWData),
        .setup_ev    (setup_ev),
        .complete_ev (complete_ev),
        .viol_ev     (viol_ev),
        .cap_addr    (cap_addr),
        .cap_write   (cap_write),
        .cap_wdata   (cap_wdata)
    );

    assign rd_dec  = decode_addr(PAddr, NUM_REGS);
    assign cmp_dec = decode_addr(cap_addr, NUM_REGS);
    assign rd_idx  = PAddr[APB_ADDR_WIDTH-1:2];
    assign cap_idx = cap_addr[APB_ADDR_WIDTH-1:2];

    always_comb begin
        status_word = '0;
        status_word[STATUS_ERR_LSB +: STATUS_CNT_W]   = err_cnt;
        status_word[STATUS_UNMAP_LSB +: STATUS_CNT_W] = unmap_cnt;
    end

    always_comb begin
        rd_data = '0;
        case (rd_dec)
            DEC_RW: begin
                for (int i = 0; i < NUM_REGS; i++)
                    if (rd_idx == IDX_W'(i))
                        rd_data = regs[i];
            end
            DEC_STATUS: rd_data = status_word;
            default:    rd_data = '0;
        endcase
    end

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= RST_VAL;
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (complete_ev && cap_write && cmp_dec == DEC_RW) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (cap_idx == IDX_W'(i)) begin
                        regs[i]     <= cap_wdata;
                        wr_pulse[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Violations and completions never coincide, so the clear cannot race an increment.
    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            err_cnt   <= '0;
            unmap_cnt <= '0;
        end else if (viol_ev) begin
            err_cnt <= sat_inc(err_cnt);
        end else if (complete_ev) begin
            if (cap_write && cmp_dec == DEC_STATUS) begin
                err_cnt   <= '0;
                unmap_cnt <= '0;
            end else if (cmp_dec == DEC_UNMAPPED) begin
                unmap_cnt <= sat_inc(unmap_cnt);
            end
        end
    end

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            PRData    <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= viol_ev;
            if (setup_ev && !PWrite)
                PRData <= rd_data;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
        assign reg_q[g*W +: W] = regs[g];
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave: directed scenarios plus randomized
// traffic compared against a register-map model kept in the bench.
module tb_apb_reg_slave;

    logic         PClk = 1'b0;
    logic         Rst  = 1'b1;
    logic [7:0]   PAddr = '0;
    logic         PSel = 1'b0;
    logic         PEnable = 1'b0;
    logic         PWrite = 1'b0;
    logic [31:0]  PWData = '0;
    logic [31:0]  PRData;
    logic [255:0] reg_q;
    logic [7:0]   wr_pulse;
    logic         proto_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl_regs [8];
    int          mdl_err;
    int          mdl_unmap;

    apb_reg_slave #(.NUM_REGS(8), .RST_VAL(32'h0)) dut (
        .PClk      (PClk),
        .Rst       (Rst),
        .PAddr     (PAddr),
        .PSel      (PSel),
        .PEnable   (PEnable),
        .PWrite    (PWrite),
        .PWData    (PWData),
        .PRData    (PRData),
        .reg_q     (reg_q),
        .wr_pulse  (wr_pulse),
        .proto_err (proto_err)
    );

    always #5 PClk = ~PClk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // 0 = RW register, 1 = STATUS, 2 = unmapped
    function automatic int mdl_kind(input logic [7:0] a);
        int ai = int'(a);
        if (ai % 4 != 0) return 2;
        if (ai / 4 < 8)  return 0;
        if (ai / 4 == 8) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [7:0] a);
        int k = mdl_kind(a);
        if (k == 0) return mdl_regs[int'(a) / 4];
        if (k == 1) return 32'(mdl_unmap * 256 + mdl_err);
        return 32'h0;
    endfunction

    function automatic logic [7:0] mdl_pulse(input logic [7:0] a, input bit wr);
        if (wr && mdl_kind(a) == 0) return 8'(1 << (int'(a) / 4));
        return 8'h0;
    endfunction

    function automatic logic [255:0] mdl_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = mdl_regs[i];
        return f;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_regs[i] = 32'h0;
        mdl_err   = 0;
        mdl_unmap = 0;
    endtask

    task automatic mdl_complete(input logic [7:0] a, input bit wr, input logic [31:0] d);
        int k = mdl_kind(a);
        if (wr && k == 0) mdl_regs[int'(a) / 4] = d;
        if (wr && k == 1) begin
            mdl_err   = 0;
            mdl_unmap = 0;
        end
        if (k == 2 && mdl_unmap < 255) mdl_unmap++;
    endtask

    task automatic mdl_violation();
        if (mdl_err < 255) mdl_err++;
    endtask

    // Bus drivers: start and end 1 time unit after a rising edge.
    task automatic bus_idle(input int n);
        PSel    = 1'b0;
        PEnable = 1'b0;
        repeat (n) begin
            @(posedge PClk); #1;
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit b2b,
                             output logic [7:0] pulse, output logic [255:0] q);
        PSel = 1'b1; PEnable = 1'b0; PAddr = a; PWrite = 1'b1; PWData = d;
        @(posedge PClk); #1;
        PEnable = 1'b1;
        @(posedge PClk); #1;
        pulse = wr_pulse;
        q     = reg_q;
        if (!b2b) begin
            PSel    = 1'b0;
            PEnable = 1'b0;
        end
    endtask

    task automatic apb_read(input logic [7:0] a, input bit b2b,
                            output logic [31:0] d_setup, output logic [31:0] d_access);
        PSel = 1'b1; PEnable = 1'b0; PAddr = a; PWrite = 1'b0; PWData = $urandom;
        @(posedge PClk); #1;
        d_setup = PRData;
        PEnable = 1'b1;
        @(posedge PClk); #1;
        d_access = PRData;
        if (!b2b) begin
            PSel    = 1'b0;
            PEnable = 1'b0;
        end
    endtask

    task automatic test_reset();
        mdl_reset();
        Rst = 1'b1;
        repeat (2) @(posedge PClk);
        #3;
        n_checks++;
        if (PRData !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h expected %h", PRData, 32'h0); end
        n_checks++;
        if (reg_q !== mdl_flat()) begin n_fail++; $display("FAIL reset_reg_q: got %h expected %h", reg_q, mdl_flat()); end
        n_checks++;
        if (wr_pulse !== 8'h0 || proto_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got wr_pulse=%h proto_err=%b expected 00/0", wr_pulse, proto_err);
        end
        Rst = 1'b0;
        @(posedge PClk); #1;
    endtask

    task automatic test_write_read();
        logic [7:0] p; logic [255:0] q; logic [31:0] ds, da, exp;
        apb_write(8'h0C, 32'hDEADBEEF, 1'b0, p, q);
        mdl_complete(8'h0C, 1'b1, 32'hDEADBEEF);
        n_checks++;
        if (p !== mdl_pulse(8'h0C, 1'b1)) begin n_fail++; $display("FAIL wr_pulse3: got %h expected %h", p, mdl_pulse(8'h0C, 1'b1)); end
        n_checks++;
        if (q !== mdl_flat()) begin n_fail++; $display("FAIL reg_q_word3: got %h expected %h", q, mdl_flat()); end
        bus_idle(1);
        n_checks++;
        if (wr_pulse !== 8'h0) begin n_fail++; $display("FAIL wr_pulse_width: got %h expected 00", wr_pulse); end
        exp = mdl_read(8'h0C);
        apb_read(8'h0C, 1'b0, ds, da);
        mdl_complete(8'h0C, 1'b0, 32'h0);
        n_checks++;
        if (ds !== exp || da !== exp) begin n_fail++; $display("FAIL read_0c: got %h/%h expected %h", ds, da, exp); end
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] p; logic [255:0] q; logic [31:0] ds, da, exp;
        apb_write(8'h00, 32'h11, 1'b1, p, q);
        mdl_complete(8'h00, 1'b1, 32'h11);
        n_checks++;
        if (p !== mdl_pulse(8'h00, 1'b1)) begin n_fail++; $display("FAIL b2b_pulse: got %h expected %h", p, mdl_pulse(8'h00, 1'b1)); end
        exp = mdl_read(8'h00);
        apb_read(8'h00, 1'b0, ds, da);
        mdl_complete(8'h00, 1'b0, 32'h0);
        n_checks++;
        if (ds !== exp || da !== exp) begin n_fail++; $display("FAIL b2b_read: got %h/%h expected %h", ds, da, exp); end
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL b2b_no_err: got %b expected 0", proto_err); end
        bus_idle(1);
    endtask

    task automatic test_violations();
        logic [31:0] ds, da, exp;
        PSel = 1'b1; PEnable = 1'b1; PAddr = 8'h08; PWrite = 1'b1; PWData = 32'hCAFE0001;
        @(posedge PClk); #1;
        mdl_violation();
        n_checks++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL viol_no_setup: got %b expected 1", proto_err); end
        bus_idle(1);
        n_checks++;
        if (proto_err !== 1'b0) begin n_fail++; $display("FAIL viol_pulse_width: got %b expected 0", proto_err); end
        PSel = 1'b1; PEnable = 1'b0; PAddr = 8'h08; PWrite = 1'b1; PWData = 32'h1234;
        @(posedge PClk); #1;
        PEnable = 1'b1; PAddr = 8'h10;
        @(posedge PClk); #1;
        mdl_violation();
        n_checks++;
        if (proto_err !== 1'b1 || wr_pulse !== 8'h0) begin
            n_fail++; $display("FAIL viol_addr_change: got err=%b pulse=%h expected 1/00", proto_err, wr_pulse);
        end
        n_checks++;
        if (reg_q !== mdl_flat()) begin n_fail++; $display("FAIL viol_no_write: got %h expected %h", reg_q, mdl_flat()); end
        bus_idle(1);
        exp = mdl_read(8'h20);
        apb_read(8'h20, 1'b0, ds, da);
        mdl_complete(8'h20, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL status_two_errs: got %h expected %h", da, exp); end
        bus_idle(1);
    endtask

    task automatic test_unmapped();
        logic [7:0] p; logic [255:0] q; logic [31:0] ds, da, exp;
        apb_write(8'h20, 32'hFFFFFFFF, 1'b0, p, q);
        mdl_complete(8'h20, 1'b1, 32'hFFFFFFFF);
        bus_idle(1);
        exp = mdl_read(8'hFC);
        apb_read(8'hFC, 1'b0, ds, da);
        mdl_complete(8'hFC, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL read_unmapped: got %h expected %h", da, exp); end
        apb_write(8'h02, 32'hA5A5A5A5, 1'b0, p, q);
        mdl_complete(8'h02, 1'b1, 32'hA5A5A5A5);
        n_checks++;
        if (p !== 8'h0 || q !== mdl_flat()) begin n_fail++; $display("FAIL misaligned_write: got pulse=%h q=%h", p, q); end
        bus_idle(1);
        exp = mdl_read(8'h20);
        apb_read(8'h20, 1'b0, ds, da);
        mdl_complete(8'h20, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL status_unmap: got %h expected %h", da, exp); end
        apb_write(8'h20, $urandom, 1'b0, p, q);
        mdl_complete(8'h20, 1'b1, 32'h0);
        bus_idle(1);
        exp = mdl_read(8'h20);
        apb_read(8'h20, 1'b0, ds, da);
        mdl_complete(8'h20, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL status_cleared: got %h expected %h", da, exp); end
        bus_idle(1);
    endtask

    task automatic test_saturation();
        logic [31:0] ds, da, exp;
        PSel = 1'b1; PEnable = 1'b1; PAddr = 8'h04; PWrite = 1'b0;
        repeat (300) begin
            @(posedge PClk);
            mdl_violation();
        end
        #1;
        n_checks++;
        if (proto_err !== 1'b1) begin n_fail++; $display("FAIL sat_err_pulse: got %b expected 1", proto_err); end
        bus_idle(1);
        exp = mdl_read(8'h20);
        apb_read(8'h20, 1'b0, ds, da);
        mdl_complete(8'h20, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL err_cnt_saturate: got %h expected %h", da, exp); end
        bus_idle(1);
    endtask

    task automatic test_reset_mid();
        logic [7:0] p; logic [255:0] q; logic [31:0] ds, da, exp;
        apb_write(8'h04, 32'h77, 1'b0, p, q);
        mdl_complete(8'h04, 1'b1, 32'h77);
        bus_idle(1);
        apb_read(8'h04, 1'b0, ds, da);
        mdl_complete(8'h04, 1'b0, 32'h0);
        bus_idle(1);
        PSel = 1'b1; PEnable = 1'b0; PAddr = 8'h04; PWrite = 1'b1; PWData = 32'h55;
        @(posedge PClk); #1;
        PEnable = 1'b1;
        #2 Rst = 1'b1;
        #1;
        mdl_reset();
        n_checks++;
        if (reg_q !== mdl_flat() || PRData !== 32'h0) begin
            n_fail++; $display("FAIL async_reset: got q=%h prdata=%h expected zero", reg_q, PRData);
        end
        @(posedge PClk);
        #3 Rst = 1'b0;
        @(posedge PClk); #1;
        mdl_violation();
        n_checks++;
        if (proto_err !== 1'b1 || wr_pulse !== 8'h0) begin
            n_fail++; $display("FAIL held_access_after_reset: got err=%b pulse=%h expected 1/00", proto_err, wr_pulse);
        end
        n_checks++;
        if (reg_q !== mdl_flat()) begin n_fail++; $display("FAIL write_dropped: got %h expected %h", reg_q, mdl_flat()); end
        bus_idle(1);
        exp = mdl_read(8'h20);
        apb_read(8'h20, 1'b0, ds, da);
        mdl_complete(8'h20, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL status_after_reset: got %h expected %h", da, exp); end
        bus_idle(1);
    endtask

    task automatic test_random();
        logic [7:0] p, a; logic [255:0] q; logic [31:0] ds, da, exp, d;
        int op, r;
        bit b2b;
        for (int it = 0; it < 80; it++) begin
            op  = int'($urandom_range(0, 4));
            r   = int'($urandom_range(0, 9));
            b2b = 1'($urandom_range(0, 1));
            if (r < 6)       a = 8'($urandom_range(0, 7) * 4);
            else if (r == 6) a = 8'h20;
            else if (r == 7) a = 8'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
            else             a = 8'($urandom_range(0, 255));
            d = $urandom;
            if (op <= 1) begin
                apb_write(a, d, b2b, p, q);
                exp = 32'(mdl_pulse(a, 1'b1));
                mdl_complete(a, 1'b1, d);
                n_checks++;
                if (p !== exp[7:0] || q !== mdl_flat()) begin
                    n_fail++; $display("FAIL rand_write a=%h: got pulse=%h q=%h expected pulse=%h q=%h", a, p, q, exp[7:0], mdl_flat());
                end
            end else if (op <= 3) begin
                exp = mdl_read(a);
                apb_read(a, b2b, ds, da);
                mdl_complete(a, 1'b0, 32'h0);
                n_checks++;
                if (ds !== exp || da !== exp) begin
                    n_fail++; $display("FAIL rand_read a=%h: got %h/%h expected %h", a, ds, da, exp);
                end
            end else begin
                PSel = 1'b1; PEnable = 1'b1; PAddr = a;
                @(posedge PClk); #1;
                mdl_violation();
                n_checks++;
                if (proto_err !== 1'b1) begin n_fail++; $display("FAIL rand_viol: got %b expected 1", proto_err); end
                bus_idle(1);
            end
        end
        bus_idle(1);
        exp = mdl_read(8'h20);
        apb_read(8'h20, 1'b0, ds, da);
        mdl_complete(8'h20, 1'b0, 32'h0);
        n_checks++;
        if (da !== exp) begin n_fail++; $display("FAIL rand_status: got %h expected %h", da, exp); end
        bus_idle(1);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_violations();
        test_unmapped();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
